// File: rtl/number_reduce_seq_if.sv
// Stream bundle for number_reduce_seq: beat input channel and result output channel.
// Both channels use valid/ready: a transfer happens on a rising edge where valid and ready are both 1.
interface number_reduce_seq_if #(
  parameter int N         = 32,
  parameter int MAX_WORDS = 16
);
  localparam int CW = $clog2(MAX_WORDS) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          in_last;
  logic [1:0]    mode;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_bits;
  logic          out_bit;
  logic [CW-1:0] out_count;
  logic          out_trunc;

  modport slave (
    input  in_valid, in_data, in_last, mode, out_ready,
    output in_ready, out_valid, out_bits, out_bit, out_count, out_trunc
  );

  modport master (
    output in_valid, in_data, in_last, mode, out_ready,
    input  in_ready, out_valid, out_bits, out_bit, out_count, out_trunc
  );
endinterface

// File: rtl/number_reduce_seq.sv
// Bitwise OR/AND/XOR reduction of a frame of beats into one registered result.
// Optional macro NUMBER_REDUCE_XOR_EN enables XOR for mode 2'b10 (otherwise it acts as OR).
module number_reduce_seq #(
  parameter int N         = 32,
  parameter int MAX_WORDS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  number_reduce_seq_if.slave bus,
  output logic [1:0]         state_dbg
);
  localparam int CW = $clog2(MAX_WORDS) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_OR  = 2'd0,
    OP_AND = 2'd1,
    OP_XOR = 2'd2
  } op_t;

  function automatic op_t decode_op(input logic [1:0] m);
    case (m)
      2'b01:   return OP_AND;
`ifdef NUMBER_REDUCE_XOR_EN
      2'b10:   return OP_XOR;
`endif
      default: return OP_OR;
    endcase
  endfunction

  function automatic logic [N-1:0] combine(input op_t op, input logic [N-1:0] a,
                                           input logic [N-1:0] b);
    case (op)
      OP_AND:  return a & b;
`ifdef NUMBER_REDUCE_XOR_EN
      OP_XOR:  return a ^ b;
`endif
      default: return a | b;
    endcase
  endfunction

  function automatic logic reduce(input op_t op, input logic [N-1:0] v);
    case (op)
      OP_AND:  return &v;
`ifdef NUMBER_REDUCE_XOR_EN
      OP_XOR:  return ^v;
`endif
      default: return |v;
    endcase
  endfunction

  state_t        state, state_next;
  op_t           op_q, op_cur;
  logic [N-1:0]  acc, acc_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          first, accept, hit_max, close_frame, drain;

  // The first beat of a frame is taken from IDLE; its mode governs the whole frame.
  assign first       = (state == S_IDLE);
  assign accept      = bus.in_valid && bus.in_ready;
  assign op_cur      = first ? decode_op(bus.mode) : op_q;
  assign acc_next    = first ? bus.in_data : combine(op_cur, acc, bus.in_data);
  assign cnt_next    = first ? CW'(1) : cnt + CW'(1);
  assign hit_max     = (cnt_next == CW'(MAX_WORDS));
  assign close_frame = accept && (bus.in_last || hit_max);
  assign drain       = (state == S_DONE) && bus.out_valid && bus.out_ready;
  assign state_dbg   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    bus.in_ready = (state != S_DONE);
    case (state)
      S_IDLE:  if (accept) state_next = bus.in_last ? S_DONE : S_ACCUM;
      S_ACCUM: if (close_frame) state_next = S_DONE;
      S_DONE:  if (drain) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Result registers are loaded from the closing beat's next-state values, giving latency 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc           <= '0;
      cnt           <= '0;
      op_q          <= OP_OR;
      bus.out_valid <= 1'b0;
      bus.out_bits  <= '0;
      bus.out_bit   <= 1'b0;
      bus.out_count <= '0;
      bus.out_trunc <= 1'b0;
    end else begin
      if (accept) begin
        acc <= acc_next;
        cnt <= cnt_next;
        if (first) op_q <= op_cur;
      end
      if (close_frame) begin
        bus.out_valid <= 1'b1;
        bus.out_bits  <= acc_next;
        bus.out_bit   <= reduce(op_cur, acc_next);
        bus.out_count <= cnt_next;
        bus.out_trunc <= hit_max && !bus.in_last;
      end
      if (drain) begin
        acc           <= '0;
        cnt           <= '0;
        op_q          <= OP_OR;
        bus.out_valid <= 1'b0;
        bus.out_bits  <= '0;
        bus.out_bit   <= 1'b0;
        bus.out_count <= '0;
        bus.out_trunc <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_number_reduce_seq.sv
// Self-checking bench for number_reduce_seq (N=8, MAX_WORDS=4) with a frame-level reference model.
module tb_number_reduce_seq;
  localparam int N  = 8;
  localparam int MW = 4;
`ifdef NUMBER_REDUCE_XOR_EN
  localparam bit XOR_EN = 1'b1;
`else
  localparam bit XOR_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] fb[0:7];

  number_reduce_seq_if #(.N(N), .MAX_WORDS(MW)) bus ();

  number_reduce_seq #(.N(N), .MAX_WORDS(MW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic void model(input logic [1:0] m, input int len, input logic last_seen,
                                output logic [7:0] eb, output logic eo, output logic et);
    int op;
    logic [7:0] acc;
    op = (m == 2'b01) ? 1 : ((m == 2'b10 && XOR_EN) ? 2 : 0);
    acc = fb[0];
    for (int i = 1; i < len; i++) begin
      if (op == 0)      acc = acc | fb[i];
      else if (op == 1) acc = acc & fb[i];
      else              acc = acc ^ fb[i];
    end
    eb = acc;
    eo = (op == 0) ? (|acc) : ((op == 1) ? (&acc) : (^acc));
    et = (len == MW) && !last_seen;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [7:0] d, input logic last, input logic [1:0] m);
    int guard = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.mode     = m;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_beat_timeout in_ready=%b required=1", bus.in_ready);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic check_result(input string name, input logic [7:0] eb, input logic eo,
                              input int ec, input logic et, input int hold);
    int guard = 0;
    @(negedge clk);
    while (!bus.out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (bus.out_valid !== 1'b1 || guard != 0) begin
      errors++;
      $display("FAIL %s latency out_valid=%b extra_cycles=%0d required 1/0", name, bus.out_valid, guard);
    end
    checks++;
    if (bus.out_bits !== eb) begin
      errors++;
      $display("FAIL %s out_bits got %h required %h", name, bus.out_bits, eb);
    end
    checks++;
    if (bus.out_bit !== eo) begin
      errors++;
      $display("FAIL %s out_bit got %b required %b", name, bus.out_bit, eo);
    end
    checks++;
    if (bus.out_count !== 3'(ec)) begin
      errors++;
      $display("FAIL %s out_count got %0d required %0d", name, bus.out_count, ec);
    end
    checks++;
    if (bus.out_trunc !== et) begin
      errors++;
      $display("FAIL %s out_trunc got %b required %b", name, bus.out_trunc, et);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_bits !== eb ||
          bus.out_count !== 3'(ec) || bus.out_trunc !== et) begin
        errors++;
        $display("FAIL %s hold%0d rdy=%b vld=%b bits=%h cnt=%0d tr=%b required 0/1/%h/%0d/%b",
                 name, i, bus.in_ready, bus.out_valid, bus.out_bits, bus.out_count,
                 bus.out_trunc, eb, ec, et);
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_bits !== 8'h00 || bus.out_count !== 3'd0 ||
        bus.out_trunc !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s drain vld=%b bits=%h cnt=%0d tr=%b rdy=%b required 0/00/0/0/1",
               name, bus.out_valid, bus.out_bits, bus.out_count, bus.out_trunc, bus.in_ready);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.mode = 2'b00;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_bits !== 8'h00 ||
        bus.out_bit !== 1'b0 || bus.out_count !== 3'd0 || bus.out_trunc !== 1'b0 ||
        state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset rdy=%b vld=%b bits=%h bit=%b cnt=%0d tr=%b st=%0d required 1/0/00/0/0/0/0",
               bus.in_ready, bus.out_valid, bus.out_bits, bus.out_bit, bus.out_count,
               bus.out_trunc, state_dbg);
    end
    rst_n = 1'b1;
    // Idle input must not start a frame.
    repeat (3) @(negedge clk);
    checks++;
    if (state_dbg !== 2'd0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold state=%0d vld=%b required 0/0", state_dbg, bus.out_valid);
    end
  endtask

  task automatic test_directed();
    send_beat(8'h01, 1'b0, 2'b00);
    send_beat(8'h10, 1'b0, 2'b00);
    send_beat(8'h80, 1'b1, 2'b00);
    check_result("or_frame", 8'h91, 1'b1, 3, 1'b0, 0);
    send_beat(8'hFF, 1'b0, 2'b01);
    send_beat(8'hF0, 1'b0, 2'b01);
    send_beat(8'h3C, 1'b1, 2'b01);
    check_result("and_frame", 8'h30, 1'b0, 3, 1'b0, 1);
    send_beat(8'h0F, 1'b0, 2'b10);
    send_beat(8'h03, 1'b1, 2'b10);
    if (XOR_EN) check_result("xor_frame", 8'h0C, 1'b0, 2, 1'b0, 0);
    else        check_result("xor_as_or", 8'h0F, 1'b1, 2, 1'b0, 0);
    send_beat(8'h77, 1'b1, 2'b11);
    check_result("reserved_single", 8'h77, 1'b1, 1, 1'b0, 0);
  endtask

  task automatic test_mode_latch();
    send_beat(8'hF0, 1'b0, 2'b01);
    send_beat(8'h3C, 1'b1, 2'b00);
    check_result("mode_latch", 8'h30, 1'b0, 2, 1'b0, 0);
  endtask

  task automatic test_truncation();
    for (int i = 0; i < 4; i++) send_beat(8'h01, 1'b0, 2'b00);
    fork
      send_beat(8'h01, 1'b0, 2'b00);
      check_result("trunc", 8'h01, 1'b1, 4, 1'b1, 2);
    join
    send_beat(8'h02, 1'b1, 2'b00);
    check_result("after_trunc", 8'h03, 1'b1, 2, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    send_beat(8'h81, 1'b0, 2'b00);
    send_beat(8'h42, 1'b1, 2'b00);
    check_result("backpressure", 8'hC3, 1'b1, 2, 1'b0, 5);
  endtask

  task automatic test_mid_reset();
    send_beat(8'h11, 1'b0, 2'b01);
    send_beat(8'h13, 1'b0, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (state_dbg !== 2'd0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.out_bits !== 8'h00 || bus.out_count !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset st=%0d rdy=%b vld=%b bits=%h cnt=%0d required 0/1/0/00/0",
               state_dbg, bus.in_ready, bus.out_valid, bus.out_bits, bus.out_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 8'hAA; bus.in_last = 1'b1; bus.mode = 2'b00;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    check_result("post_reset", 8'hAA, 1'b1, 1, 1'b0, 0);
    // Reset while a result is pending must drop it at once.
    send_beat(8'h55, 1'b1, 2'b00);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_bits !== 8'h00 || bus.out_bit !== 1'b0 ||
        bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL done_reset vld=%b bits=%h bit=%b rdy=%b required 0/00/0/1",
               bus.out_valid, bus.out_bits, bus.out_bit, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [7:0] eb;
    logic eo, et, trunc, last;
    logic [1:0] m0;
    int len;
    for (int f = 0; f < 40; f++) begin
      trunc = ($urandom_range(0, 3) == 0);
      len   = trunc ? MW : $urandom_range(1, MW);
      m0    = 2'($urandom_range(0, 3));
      for (int i = 0; i < len; i++) begin
        fb[i] = ($urandom_range(0, 1) == 1) ? (8'hFF ^ 8'(1 << $urandom_range(0, 7)))
                                            : 8'($urandom);
        last  = !trunc && (i == len - 1);
        send_beat(fb[i], last, (i == 0) ? m0 : 2'($urandom_range(0, 3)));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      model(m0, len, !trunc, eb, eo, et);
      check_result("random", eb, eo, len, et, $urandom_range(0, 3));
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_mode_latch();
    test_truncation();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/number_reduce_seq.md
NUMBER_REDUCE_SEQ -- requirements
Module: number_reduce_seq

Interface
REQ-001 SHALL have parameter N, default 32: data word width in bits, N >= 2.
REQ-002 SHALL have parameter MAX_WORDS, default 16: maximum number of beats per frame, MAX_WORDS >= 2.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: the input beat is valid.
REQ-006 SHALL have port in_ready, output, 1: the block accepts a beat.
REQ-007 SHALL have port in_data, input, N: the input word.
REQ-008 SHALL have port in_last, input, 1: the beat is the final beat of the frame.
REQ-009 SHALL have port mode, input, 2: 00 OR, 01 AND, 10 XOR, 11 reserved (treated as OR).
REQ-010 SHALL have port out_valid, output, 1: the result is valid.
REQ-011 SHALL have port out_ready, input, 1: the consumer accepts the result.
REQ-012 SHALL have port out_bits, output, N: the bitwise accumulation over the frame.
REQ-013 SHALL have port out_bit, output, 1: the reduction of all bits of out_bits, using the same operator.
REQ-014 SHALL have port out_count, output, $clog2(MAX_WORDS)+1: the number of beats in the frame.
REQ-015 SHALL have port out_trunc, output, 1: the frame was closed by reaching MAX_WORDS rather than by in_last.

Function
REQ-016 SHALL implement the FSM states IDLE, ACCUM and DONE.
REQ-017 SHALL accept a beat on any edge where in_valid and in_ready are both 1.
- in_ready is 1 in IDLE and ACCUM, 0 in DONE.
REQ-018 SHALL latch mode on the first accepted beat of a frame; mode changes during the rest of the frame SHALL be ignored.
REQ-019 SHALL load the accumulator with in_data on the first beat of a frame, and update it as acc OP in_data on each later beat.
REQ-020 SHALL increment the beat counter on every accepted beat; the first beat sets it to 1.
REQ-021 SHALL move IDLE->ACCUM on a first beat with in_last=0.
REQ-022 SHALL move IDLE->DONE on a first beat with in_last=1.
REQ-023 SHALL move ACCUM->DONE on an accepted beat with in_last=1, or on the beat that makes the count equal MAX_WORDS.
- out_trunc=1 only when the count reaches MAX_WORDS while in_last=0.
REQ-024 SHALL assert out_valid the cycle after the closing beat, registered (latency 1); out_bits, out_bit, out_count and out_trunc SHALL be stable while out_valid=1.
REQ-025 SHALL hold DONE while out_ready=0, and move DONE->IDLE on out_valid and out_ready both 1; outputs then return to reset values on the next cycle.
REQ-026 SHALL register out_bit, computed from the final accumulator: OR-reduce, AND-reduce or XOR-reduce of out_bits.
REQ-027 SHALL not enter ACCUM when in_valid=0 in IDLE, and SHALL hold state and accumulator when in_valid=0 in ACCUM.

Reset
REQ-028 SHALL, on rst_n=0 at any time including mid-frame, immediately return to IDLE.
- Values: in_ready=1, out_valid=0, out_bits=0, out_bit=0, out_count=0, out_trunc=0, accumulator=0, counter=0, latched mode=OR.
REQ-029 SHALL accept a new frame on the first rising edge after rst_n deasserts.

Configuration
REQ-030 SHALL, when macro NUMBER_REDUCE_XOR_EN is defined, implement mode 10 as XOR, as specified.
REQ-031 SHALL, when NUMBER_REDUCE_XOR_EN is undefined, treat mode 10 identically to OR and include no XOR logic.

Verification
REQ-032 SHALL cover OR mode, N=8, MAX_WORDS=4: beats 0x01, 0x10, 0x80(last) -> out_bits=0x91, out_bit=1, out_count=3, out_trunc=0.
REQ-033 SHALL cover AND mode: beats 0xFF, 0xF0, 0x3C(last) -> out_bits=0x30, out_bit=0, out_count=3.
REQ-034 SHALL cover XOR mode with NUMBER_REDUCE_XOR_EN defined: beats 0x0F, 0x03(last) -> out_bits=0x0C, out_bit=0.
- Same stimulus without the macro -> out_bits=0x0F, out_bit=1.
REQ-035 SHALL cover truncation: 5 OR beats of 0x01 with in_last=0 -> result after beat 4 with out_count=4, out_trunc=1; beat 5 SHALL start a new frame once DONE clears.
REQ-036 SHALL cover back-pressure: out_ready=0 for 5 cycles -> in_ready=0, outputs stable; out_ready=1 -> DONE->IDLE and in_ready=1 on the next cycle.
REQ-037 SHALL cover mid-frame reset: rst_n pulse after beat 2 -> all outputs 0 immediately; a following single-beat frame 0xAA(last), OR -> out_bits=0xAA, out_count=1.
